// File: rtl/div_clk_monitor.sv
// div_clk_monitor: divided-clock period/duty/stall checker; define DIV_CLK_MONITOR_SYNC2_EN for a two-flop input synchronizer
module div_clk_monitor #(
  parameter int DIV = 5,
  parameter int CNT_W = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_i,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stall
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(2 * DIV);
  localparam logic [CNT_W-1:0] STALL_C = CNT_W'(2 * DIV - 1);
  localparam logic [CNT_W-1:0] HLO_C = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] HHI_C = CNT_W'((DIV + 1) / 2);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT - 1);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t state, state_nxt;
  logic s0, s0_d;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [MW-1:0] mcnt;
  logic rise, active, match, duty_ok, stall, pub;
  assign rise = s0 & ~s0_d;
  assign active = state != IDLE;
  assign match = cnt == DIV_C;
  assign duty_ok = hcnt == HLO_C || hcnt == HHI_C;
  assign stall = active & ~rise & (cnt == STALL_C);
  assign pub = active & rise;
`ifdef DIV_CLK_MONITOR_SYNC2_EN
  logic m0;
  always_ff @(posedge clk) begin
    m0 <= rst ? clk_i : 1'b0;
    s0 <= rst ? m0 : 1'b0;
  end
`else
  always_ff @(posedge clk)
    s0 <= rst ? clk_i : 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? state_nxt : IDLE;
  always_comb begin
    state_nxt = stall ? IDLE :
                (state == IDLE && rise) ? MEASURE :
                (state == MEASURE && rise && match && mcnt == LOCK_M) ? LOCKED :
                (state == LOCKED && rise && !match) ? MEASURE : state;
  end
  always_comb begin
    locked = state == LOCKED;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_d <= 1'b0;
      cnt <= '0;
      hcnt <= '0;
      mcnt <= '0;
      period <= '0;
      high_time <= '0;
      meas_valid <= 1'b0;
      err_period <= 1'b0;
      err_duty <= 1'b0;
      err_stall <= 1'b0;
    end else begin
      s0_d <= s0;
      cnt <= rise ? CNT_W'(1) : (cnt == MAX_C ? cnt : cnt + 1'b1);
      hcnt <= rise ? CNT_W'(1) : ((s0 && hcnt != MAX_C) ? hcnt + 1'b1 : hcnt);
      meas_valid <= pub;
      period <= pub ? cnt : period;
      high_time <= pub ? hcnt : high_time;
      mcnt <= stall ? '0 : !pub ? mcnt : !match ? '0 : (state == MEASURE) ? mcnt + 1'b1 : mcnt;
      err_period <= err_period | (pub & ~match);
      err_duty <= err_duty | (pub & ~duty_ok);
      err_stall <= err_stall | stall;
    end
  end
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: scoreboard bench driving pulse trains and checking every published measurement
module tb_div_clk_monitor;
  localparam int DIV = 5;
  localparam int CNT_W = 8;
  localparam int LOCK_CNT = 4;
`ifdef DIV_CLK_MONITOR_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk, rst, clk_i;
  logic [CNT_W-1:0] period, high_time;
  logic meas_valid, locked, err_period, err_duty, err_stall;
  typedef struct {
    int p;
    int h;
    bit lk;
    bit ep;
    bit ed;
    bit es;
    int cy;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_state, m_mcnt, ph, pl;
  bit m_ep, m_ed, m_es;
  div_clk_monitor #(.DIV(DIV), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst(rst), .clk_i(clk_i), .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .locked(locked), .err_period(err_period),
    .err_duty(err_duty), .err_stall(err_stall)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0;
    m_mcnt = 0;
    m_ep = 0;
    m_ed = 0;
    m_es = 0;
  endtask
  // Period-level reference: each rise publishes the pulse that preceded it.
  task automatic model_rise(input int h, input int l);
    int p;
    exp_t x;
    p = ph + pl;
    if (m_state == 0) m_state = 1;
    else if (p >= 2 * DIV) begin
      m_es = 1;
      m_mcnt = 0;
      m_state = 1;
    end else begin
      if (ph != DIV / 2 && ph != (DIV + 1) / 2) m_ed = 1;
      if (p == DIV) begin
        if (m_state == 1) begin
          m_mcnt++;
          if (m_mcnt == LOCK_CNT) m_state = 2;
        end
      end else begin
        m_ep = 1;
        m_mcnt = 0;
        m_state = 1;
      end
      x.p = p;
      x.h = ph;
      x.lk = m_state == 2;
      x.ep = m_ep;
      x.ed = m_ed;
      x.es = m_es;
      x.cy = cyc + LAT;
      sbq.push_back(x);
    end
    ph = h;
    pl = l;
  endtask
  task automatic pulse(input int h, input int l);
    model_rise(h, l);
    clk_i = 1;
    repeat (h) @(negedge clk);
    clk_i = 0;
    repeat (l) @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high_time"}, high_time, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_period"}, err_period, 0);
    check({tag, "_err_duty"}, err_duty, 0);
    check({tag, "_err_stall"}, err_stall, 0);
  endtask
  always @(negedge clk) begin
    if (rst === 1'b1 && meas_valid === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_meas_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        check("mv_cycle", cyc, e.cy);
        check("period", period, e.p);
        check("high_time", high_time, e.h);
        check("locked", locked, e.lk);
        check("err_period", err_period, e.ep);
        check("err_duty", err_duty, e.ed);
        check("err_stall", err_stall, e.es);
      end
    end
  end
  initial begin
    int n;
    rst = 0;
    clk_i = 0;
    ph = 0;
    pl = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1;
    repeat (3) @(negedge clk);
    repeat (7) pulse(3, 2);
    pulse(3, 3);
    repeat (6) pulse(3, 2);
    pulse(1, 4);
    repeat (3) pulse(2, 3);
    n = cyc;
    model_rise(2, 30);
    clk_i = 1;
    repeat (2) @(negedge clk);
    clk_i = 0;
    while (cyc < n + LAT + 2 * DIV - 2) @(negedge clk);
    check("stall_early_err_stall", err_stall, 0);
    check("stall_early_locked", locked, 1);
    @(negedge clk);
    check("stall_err_stall", err_stall, 1);
    check("stall_locked", locked, 0);
    while (cyc < n + 32) @(negedge clk);
    repeat (7) pulse(3, 2);
    check("pre_reset_locked", locked, 1);
    rst = 0;
    @(negedge clk);
    check_zero("midreset");
    rst = 1;
    model_reset();
    repeat (7) pulse(2, 3);
    repeat (20) pulse($urandom_range(1, 4), $urandom_range(1, 5));
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Downstream checker for the odd-ratio clock divider. It samples the divided clock as data in the `clk` domain and measures its period and high time in `clk` cycles. It declares lock after a run of correct periods and raises sticky error flags on period, duty or stall faults. It sits beside the divider output and feeds status to the bring-up/debug register block.

## Interface
- `DIV`, 5: expected divide ratio (period in `clk` cycles), ≥ 2.
- `CNT_W`, 8: counter/measurement width; `2*DIV` must be < 2^CNT_W.
- `LOCK_CNT`, 4: consecutive matching periods required to assert `locked`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `clk_i`  in  1  divided clock from the divider, treated as asynchronous data.
- `period`  out  CNT_W  last measured period, in cycles.
- `high_time`  out  CNT_W  last measured high time, in cycles.
- `meas_valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `locked`  out  1  `LOCK_CNT` consecutive periods equal to `DIV`.
- `err_period`  out  1  sticky: measured period ≠ `DIV`.
- `err_duty`  out  1  sticky: high time outside the allowed range.
- `err_stall`  out  1  sticky: no rising edge for `2*DIV` cycles.

## Operation
- Input path: `s0 <= clk_i`, `s0_d <= s0`. `rise = s0 & ~s0_d`.
- `cnt`: set to 1 on `rise`, otherwise +1, saturating at `2*DIV`. `hcnt`: set to 1 on `rise`, otherwise +1 while `s0`=1.
- FSM states: IDLE, MEASURE, LOCKED. Reset state is IDLE.
- IDLE: first `rise` goes to MEASURE. Nothing is published and `meas_valid` stays 0.
- MEASURE/LOCKED, on `rise`:
  - `period <= cnt`, `high_time <= hcnt`, `meas_valid <= 1`.
  - Match means `cnt == DIV`. Duty is OK when `hcnt` ∈ {floor(DIV/2), ceil(DIV/2)}.
- MEASURE:
  - On a match, the match counter increments.
  - When the count reaches `LOCK_CNT`, go to LOCKED and set `locked=1` on the same edge.
  - On a mismatch, clear the match counter and set `err_period`.
- LOCKED: on a mismatch, set `err_period`, drop `locked`, clear the match counter and go to MEASURE, all on the same edge.
- Duty violation in any non-IDLE state sets `err_duty`. It does not affect lock.
- Stall: in MEASURE/LOCKED, when `cnt` reaches `2*DIV` without `rise`:
  - Set `err_stall`, clear `locked` and the match counter, and go to IDLE.
  - The next `rise` restarts from IDLE behaviour.
- Simultaneous events:
  - A mismatch on the edge that would complete lock means no lock.
  - A period and a duty error on the same rise set both flags.
- Error flags stay set until reset.

## Timing
- Reset values (one edge with `rst`=0): `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, all `err_*`=0, `s0`=`s0_d`=0, counters 0, state IDLE.
- Reset asserted mid-operation clears everything on that edge, regardless of state.
- Latency: `clk_i` is high at edge k. `s0`=1 after edge k, `rise` is true during cycle k+1, and outputs update at edge k+1. So `meas_valid` is high in the cycle after edge k+1, i.e. 2 edges from sampling.
- `meas_valid` is exactly one cycle wide. Outputs hold their values between pulses.
- `locked`/`err_*` change on the same edge as the corresponding `meas_valid` rise.
- Stall flag timing: `err_stall` sets on the edge where `cnt` would reach `2*DIV`.
- Widths: all counters are `CNT_W` unsigned and never wrap, because of the saturation.

## Configuration
- `DIV_CLK_MONITOR_SYNC2_EN`:
  - Defined: adds a second synchronizer flop (`clk_i`→`m0`→`s0`). `rise` is derived from `s0`/`s0_d` unchanged, and all latencies grow by exactly one edge (3 edges to `meas_valid`). Reset clears `m0`.
  - Undefined: single-flop sampling as above.

## Test plan
- Nominal: `DIV`=5, feed a 50%-duty ÷5 waveform (edges allowed on `clk` falling edges).
  - Required: first `meas_valid` shows `period`=5 and `high_time` ∈ {2,3}.
  - `locked`=1 on the 4th post-IDLE rise, no errors.
- Period fault: after lock, insert one period of 6 cycles.
  - Required: `period`=6, `err_period`=1 and `locked`=0 on that `meas_valid`.
  - Relock after 4 more good periods; `err_period` stays 1.
- Duty fault: period 5 with `clk_i` high for 1 cycle.
  - Required: `err_duty`=1, `locked` unaffected, `high_time`=1.
- Stall: hold `clk_i`=0 after lock.
  - Required: `err_stall`=1 and `locked`=0 exactly 10 cycles after the last rise.
  - Next rise publishes nothing (IDLE).
- Reset mid-lock: drive `rst`=0 for one edge while LOCKED with errors set.
  - Required: all outputs 0 after that edge.
  - First `meas_valid` arrives on the second rise after release.
- Macro: rerun nominal with `DIV_CLK_MONITOR_SYNC2_EN`.
  - Required: every `meas_valid` is one cycle later than the baseline run, with identical values.
